// File: rtl/cmp_arbiter_pkg.sv
// Shared compare definitions: the 3-bit condition type and its codes.
// Codes 6 and 7 are valid encodings that always evaluate to 0.
package cmp_arbiter_pkg;

  typedef logic [2:0] cmp_cond_t;

  localparam cmp_cond_t CMP_EQ  = 3'd0;
  localparam cmp_cond_t CMP_NEQ = 3'd1;
  localparam cmp_cond_t CMP_GT  = 3'd2;
  localparam cmp_cond_t CMP_GTE = 3'd3;
  localparam cmp_cond_t CMP_LT  = 3'd4;
  localparam cmp_cond_t CMP_LTE = 3'd5;

endpackage

// File: rtl/cmp_arbiter_rr_pick.sv
// Round-robin priority picker: grants the first requester with req set,
// scanning upward from ptr_i and wrapping modulo NREQ. Purely combinational.
module cmp_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  // Scan from the pointer; the first hit wins and later hits are ignored.
  always_comb begin
    logic found;
    int   k;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (en_i && !found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Shared 16-bit compare unit with round-robin arbitration between NREQ
// requesters and a single registered result slot with backpressure.
// An accepted request is compared in its accept cycle; the result appears
// one cycle later and is held until the consumer takes it.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ*3-1:0] sel_in,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic            cmp_out,
  input  logic            rsp_ready
);

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            cmp_q, cmp_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            slot_full;
  logic            can_issue;
  logic            accept;
  logic [IDW-1:0]  pick_idx;
  logic [W-1:0]    a_sel, b_sel;
  cmp_cond_t       sel_sel;
  logic            cmp_res;

  // A new compare may issue when the slot is empty or is being drained now.
  // Grants are suppressed while reset is asserted.
  assign slot_full = |rsp_valid_q;
  assign can_issue = ~slot_full | rsp_ready;

  cmp_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .en_i  (can_issue & rst_n),
    .gnt_o (gnt),
    .idx_o (pick_idx)
  );

  assign accept  = |gnt;
  assign a_sel   = a_in[int'(pick_idx)*W +: W];
  assign b_sel   = b_in[int'(pick_idx)*W +: W];
  assign sel_sel = sel_in[int'(pick_idx)*3 +: 3];

  // Unsigned compare of the granted requester's operands.
  always_comb begin
    cmp_res = 1'b0;
    case (sel_sel)
      CMP_EQ:  cmp_res = (a_sel == b_sel);
      CMP_NEQ: cmp_res = (a_sel != b_sel);
      CMP_GT:  cmp_res = (a_sel >  b_sel);
      CMP_GTE: cmp_res = (a_sel >= b_sel);
      CMP_LT:  cmp_res = (a_sel <  b_sel);
      CMP_LTE: cmp_res = (a_sel <= b_sel);
      default: cmp_res = 1'b0;
    endcase
  end

  // Slot next state: refill on accept, drop valid on a pop with no refill,
  // otherwise hold. Id and result keep their last values after a pop.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    cmp_d       = cmp_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      rsp_valid_d = gnt;
      rsp_id_d    = pick_idx;
      cmp_d       = cmp_res;
      rr_ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = '0;
    end
  end

  // State registers; reset discards any pending result and rewinds the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      cmp_q       <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      cmp_q       <= cmp_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign cmp_out   = cmp_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level reference model.
module tb_cmp_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ*3-1:0] sel_in;
  logic              rsp_ready;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              cmp_out;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_ptr;
  bit m_full;
  int m_id;
  bit m_cmp;

  cmp_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .sel_in    (sel_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .cmp_out   (cmp_out),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic bit ref_cmp(int a, int b, int s);
    case (s)
      0: return a == b;
      1: return a != b;
      2: return a > b;
      3: return a >= b;
      4: return a < b;
      5: return a <= b;
      default: return 1'b0;
    endcase
  endfunction

  // Requester index the model expects to be granted now, or -1.
  function automatic int exp_pick();
    if (rst_n !== 1'b1) return -1;
    if (m_full && !rsp_ready) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_gnt();
    logic [NREQ-1:0] g;
    int k;
    g = '0;
    k = exp_pick();
    if (k >= 0) g[k] = 1'b1;
    return g;
  endfunction

  function automatic logic [NREQ-1:0] exp_valid();
    logic [NREQ-1:0] v;
    v = '0;
    if (m_full) v[m_id] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_full = 1'b0; m_id = 0; m_cmp = 1'b0;
  endtask

  // Advance the model by the edge about to happen, then step the clock.
  task automatic tick();
    int k;
    k = exp_pick();
    if (k >= 0) begin
      m_full = 1'b1;
      m_id   = k;
      m_cmp  = ref_cmp(int'(a_in[k*W +: W]), int'(b_in[k*W +: W]), int'(sel_in[k*3 +: 3]));
      m_ptr  = (k + 1) % NREQ;
    end else if (rst_n === 1'b1 && rsp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int k, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] s);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
    sel_in[k*3 +: 3] = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req = NREQ'($urandom);
    rsp_ready = 1'b1;
    tick();
    tick();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (cmp_out !== 1'b0) begin errors++; $display("FAIL reset_cmp: got %b want 0", cmp_out); end
    rst_n = 1'b1;
    req = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (gnt !== '0 || rsp_valid !== '0 || rsp_id !== '0 || cmp_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got gnt=%b vld=%b id=%0d cmp=%b want all 0", i, gnt, rsp_valid, rsp_id, cmp_out);
      end
      tick();
    end
  endtask

  task automatic test_single();
    bit exp_c [2] = '{1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req = 4'b0001;
      set_op(0, 16'h1234, 16'h1234, 3'(s));
      #1;
      checks++; if (gnt !== 4'b0001 || gnt !== exp_gnt()) begin errors++; $display("FAIL single_gnt sel=%0d: got %b want 0001", s, gnt); end
      tick();
      req = '0;
      #1;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || cmp_out !== exp_c[s] || cmp_out !== m_cmp) begin
        errors++;
        $display("FAIL single_rsp sel=%0d: got vld=%b id=%0d cmp=%b want vld=0001 id=0 cmp=%b", s, rsp_valid, rsp_id, cmp_out, exp_c[s]);
      end
      tick();
    end
  endtask

  task automatic test_unsigned();
    logic [W-1:0] ta [5] = '{16'h8000, 16'h8000, 16'd5, 16'd5, 16'd5};
    logic [W-1:0] tb [5] = '{16'h7FFF, 16'h7FFF, 16'd5, 16'd5, 16'd5};
    logic [2:0]   ts [5] = '{3'd2, 3'd4, 3'd3, 3'd5, 3'd6};
    bit           te [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req = 4'b0100;
      set_op(2, ta[i], tb[i], ts[i]);
      #1;
      tick();
      req = '0;
      #1;
      checks++;
      if (cmp_out !== te[i] || cmp_out !== m_cmp || rsp_valid !== 4'b0100 || rsp_id !== 2'd2) begin
        errors++;
        $display("FAIL unsigned_cmp[%0d] sel=%0d: got cmp=%b vld=%b id=%0d want cmp=%b vld=0100 id=2", i, ts[i], cmp_out, rsp_valid, rsp_id, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) set_op(k, 16'($urandom), 16'($urandom), 3'($urandom));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (gnt !== seq[i] || gnt !== exp_gnt()) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, seq[i]); end
      if (i > 0) begin
        checks++;
        if (rsp_valid !== seq[i-1] || cmp_out !== m_cmp) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got vld=%b cmp=%b want vld=%b cmp=%b", i, rsp_valid, cmp_out, seq[i-1], m_cmp);
        end
      end
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] h_vld;
    logic [IDW-1:0]  h_id;
    logic            h_cmp;
    rsp_ready = 1'b1;
    req = 4'b0001;
    set_op(0, 16'h0010, 16'h0020, 3'd4);
    set_op(1, 16'h00FF, 16'h00FF, 3'd0);
    set_op(2, 16'h0001, 16'h0002, 3'd2);
    #1;
    tick();
    h_vld = rsp_valid; h_id = rsp_id; h_cmp = cmp_out;
    checks++; if (h_vld !== 4'b0001 || h_cmp !== 1'b1) begin errors++; $display("FAIL bp_setup: got vld=%b cmp=%b want vld=0001 cmp=1", h_vld, h_cmp); end
    rsp_ready = 1'b0;
    req = 4'b0110;
    set_op(0, 16'h0030, 16'h0020, 3'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gnt !== '0) begin errors++; $display("FAIL bp_gnt[%0d]: got %b want 0", i, gnt); end
      checks++;
      if (rsp_valid !== h_vld || rsp_id !== h_id || cmp_out !== h_cmp || rsp_valid !== exp_valid()) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b id=%0d cmp=%b want vld=%b id=%0d cmp=%b", i, rsp_valid, rsp_id, cmp_out, h_vld, h_id, h_cmp);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0010 || gnt !== exp_gnt()) begin errors++; $display("FAIL bp_release_gnt: got %b want 0010", gnt); end
    tick();
    req = '0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_id !== 2'd1 || cmp_out !== 1'b1 || cmp_out !== m_cmp) begin
      errors++;
      $display("FAIL bp_refill: got vld=%b id=%0d cmp=%b want vld=0010 id=1 cmp=1", rsp_valid, rsp_id, cmp_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    req = 4'b0001;
    set_op(0, 16'h0003, 16'h0003, 3'd0);
    #1;
    tick();
    rsp_ready = 1'b0;
    req = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_pending: got %b want 0001", rsp_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rsp_valid !== '0 || gnt !== '0 || cmp_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got vld=%b gnt=%b cmp=%b want 0", rsp_valid, gnt, cmp_out);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL mid_no_pulse: got %b want 0", rsp_valid); end
    tick();
    for (int k = 0; k < NREQ; k++) set_op(k, 16'($urandom), 16'($urandom), 3'($urandom));
    req = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001 || gnt !== exp_gnt()) begin errors++; $display("FAIL mid_first_gnt: got %b want 0001", gnt); end
    tick();
    req = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0001 || cmp_out !== m_cmp) begin errors++; $display("FAIL mid_first_rsp: got vld=%b cmp=%b want vld=0001 cmp=%b", rsp_valid, cmp_out, m_cmp); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req = NREQ'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      for (int k = 0; k < NREQ; k++) begin
        logic [W-1:0] a;
        a = 16'($urandom);
        if ($urandom % 3 == 0) set_op(k, a, a, 3'($urandom));
        else if ($urandom % 2 == 0) set_op(k, a, a + 16'($urandom_range(1, 2)), 3'($urandom));
        else set_op(k, a, 16'($urandom), 3'($urandom));
      end
      #1;
      checks++;
      if (gnt !== exp_gnt() || rsp_valid !== exp_valid() || rsp_id !== IDW'(m_id) || cmp_out !== m_cmp) begin
        errors++;
        $display("FAIL random[%0d]: got gnt=%b vld=%b id=%0d cmp=%b want gnt=%b vld=%b id=%0d cmp=%b",
                 n, gnt, rsp_valid, rsp_id, cmp_out, exp_gnt(), exp_valid(), m_id, m_cmp);
      end
      tick();
    end
    req = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    a_in = '0;
    b_in = '0;
    sel_in = '0;
    rsp_ready = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_unsigned();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
